// File: rtl/datapath_pkg.sv
// Shared definitions for the multi-cycle datapath.
//   state_t  : controller states FETCH, DECODE, EXEC, WB, HALT
//   OP_*     : primary opcode values (instruction bits [31:26])
//   FN_*     : R-type funct values (instruction bits [5:0])
//   alu_op_t : operation selector for alu_param
//   decode_alu / insn_known : map an instruction onto an ALU op / writability
package datapath_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT
    } alu_op_t;

    // Unknown opcodes/functs still run through the adder so the flags have
    // a defined source; their result is simply never written back.
    function automatic alu_op_t decode_alu(input logic [5:0] opcode,
                                           input logic [5:0] funct);
        alu_op_t op;
        op = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SUB:  op = ALU_SUB;
                FN_AND:  op = ALU_AND;
                FN_OR:   op = ALU_OR;
                FN_XOR:  op = ALU_XOR;
                FN_NOR:  op = ALU_NOR;
                FN_SLT:  op = ALU_SLT;
                default: op = ALU_ADD;
            endcase
        end
        return op;
    endfunction

    function automatic logic insn_known(input logic [5:0] opcode,
                                        input logic [5:0] funct);
        logic known;
        known = 1'b0;
        if (opcode == OP_ADDI) begin
            known = 1'b1;
        end else if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD, FN_SUB, FN_AND, FN_OR,
                FN_XOR, FN_NOR, FN_SLT: known = 1'b1;
                default:                known = 1'b0;
            endcase
        end
        return known;
    endfunction

endpackage

// File: rtl/alu_param.sv
// Combinational XLEN-wide ALU.
//   a, b   : operands
//   op     : operation select (alu_op_t)
//   result : operation result
//   n,z,c,v: negative, zero, carry (no-borrow for sub), signed overflow;
//            c and v are forced to 0 for everything except add and sub
module alu_param
    import datapath_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] result,
    output logic            n,
    output logic            z,
    output logic            c,
    output logic            v
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;
    logic          lt;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Subtract as a + ~b + 1 so the carry-out reads as "no borrow".
    assign diff = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
    assign lt   = $signed(a) < $signed(b);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through the block leaves one unassigned (which would infer a latch).
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum[XLEN-1:0];
                c      = sum[XLEN];
                v      = (a[XLEN-1] == b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
            end
            ALU_SUB: begin
                result = diff[XLEN-1:0];
                c      = diff[XLEN];
                v      = (a[XLEN-1] != b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = XLEN'(lt);
            default: result = '0;
        endcase
        n = result[XLEN-1];
        z = (result == '0);
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core: FETCH -> DECODE -> EXEC -> WB, plus HALT.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   imem_req, imem_addr : fetch request and byte address (current PC)
//   imem_valid, imem_data : instruction return from memory
//   Dout    : last written-back result
//   flags   : {N,Z,C,V} of the last executed ALU operation
//   retired : completed-instruction counter (wraps)
//   halted  : core has executed the halt opcode
module multicycle_datapath
    import datapath_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_data,
    output logic [XLEN-1:0]  Dout,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] retired,
    output logic             halted
);

    localparam int RW = $clog2(NREGS);

    state_t            state, state_nx;
    logic [31:0]       ir;
    logic [PC_W-1:0]   pc;
    logic [XLEN-1:0]   a_q, b_q, alu_out;
    logic [XLEN-1:0]   regs [NREGS];

    // Instruction fields; register indices use only the low RW bits.
    logic [5:0]        opcode, funct;
    logic [RW-1:0]     rs_idx, rt_idx, rd_idx, wr_idx;
    logic [XLEN-1:0]   rs_val, rt_val, imm_sext;
    logic              wr_en;
    logic              unused_shamt;

    alu_op_t           alu_op;
    logic [XLEN-1:0]   alu_res;
    logic              alu_n, alu_z, alu_c, alu_v;

    assign opcode   = ir[31:26];
    assign funct    = ir[5:0];
    assign rs_idx   = ir[21 +: RW];
    assign rt_idx   = ir[16 +: RW];
    assign rd_idx   = ir[11 +: RW];
    assign imm_sext = XLEN'($signed(ir[15:0]));
    assign unused_shamt = ^ir[10:6];

    assign rs_val = (rs_idx == '0) ? '0 : regs[rs_idx];
    assign rt_val = (rt_idx == '0) ? '0 : regs[rt_idx];

    assign wr_idx = (opcode == OP_ADDI) ? rt_idx : rd_idx;
    assign wr_en  = insn_known(opcode, funct) && (wr_idx != '0);
    assign alu_op = decode_alu(opcode, funct);

    // Request drops immediately while reset is held, not just after the edge.
    assign imem_req  = (state == FETCH) && reset;
    assign imem_addr = pc;

    alu_param #(.XLEN(XLEN)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (alu_op),
        .result (alu_res),
        .n      (alu_n),
        .z      (alu_z),
        .c      (alu_c),
        .v      (alu_v)
    );

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge.
        if (!reset) state <= FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   if (imem_valid) state_nx = DECODE;
            DECODE:  state_nx = (opcode == OP_HALT) ? HALT : EXEC;
            EXEC:    state_nx = WB;
            WB:      state_nx = FETCH;
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= '0;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_out <= '0;
            Dout    <= '0;
            flags   <= '0;
            retired <= '0;
            halted  <= 1'b0;
            // NOTE: the register file is architecturally cleared by reset,
            // so it is built from flops rather than an inferred RAM.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_valid) ir <= imem_data;
                end
                DECODE: begin
                    a_q <= rs_val;
                    b_q <= (opcode == OP_ADDI) ? imm_sext : rt_val;
                    if (opcode == OP_HALT) halted <= 1'b1;
                end
                EXEC: begin
                    alu_out <= alu_res;
                    flags   <= {alu_n, alu_z, alu_c, alu_v};
                end
                WB: begin
                    if (wr_en) begin
                        regs[wr_idx] <= alu_out;
                        Dout         <= alu_out;
                    end
                    pc      <= pc + PC_W'(4);
                    retired <= retired + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: a small instruction memory with a
// programmable response delay, hand-encoded program, hand-computed results.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic [31:0] Dout;
    logic [3:0]  flags;
    logic [15:0] retired;
    logic        halted;

    logic [31:0] mem [64];
    int          mem_delay;
    int          wcnt;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    multicycle_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .Dout       (Dout),
        .flags      (flags),
        .retired    (retired),
        .halted     (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait for the next retirement (bounded) and check its cycle count.
    task automatic wait_retire(input string tag, input int exp_cyc, output int cyc);
        logic [15:0] prev;
        prev = retired;
        cyc  = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (retired == prev && cyc < 40);
        check({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    endtask

    // Memory responder: answers mem_delay cycles after the request appears.
    initial begin
        imem_valid = 1'b0;
        imem_data  = '0;
        wcnt       = 0;
        forever begin
            @(negedge clk); #1;
            if (imem_req) begin
                if (wcnt >= mem_delay) begin
                    imem_valid = 1'b1;
                    imem_data  = mem[imem_addr[7:2]];
                end else begin
                    imem_valid = 1'b0;
                    wcnt++;
                end
            end else begin
                imem_valid = 1'b0;
                wcnt       = 0;
            end
        end
    end

    initial begin
        int c, total;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0]  = 32'h20010005; // addi $1,$0,5
        mem[1]  = 32'h2002FFFD; // addi $2,$0,-3
        mem[2]  = 32'h00221820; // add  $3,$1,$2
        mem[3]  = 32'h00212022; // sub  $4,$1,$1
        mem[4]  = 32'h20058000; // addi $5,$0,-32768
        for (int i = 5; i <= 20; i++) mem[i] = 32'h00A52820; // add $5,$5,$5
        mem[21] = 32'h00A02827; // nor  $5,$5,$0  -> 0x7FFFFFFF
        mem[22] = 32'h00A53020; // add  $6,$5,$5
        mem[23] = 32'h00210020; // add  $0,$1,$1
        mem[24] = 32'h00013820; // add  $7,$0,$1
        mem[25] = 32'h0041402A; // slt  $8,$2,$1
        mem[26] = 32'h0021483E; // unknown funct, rd=$9
        mem[27] = 32'h01206820; // add  $13,$9,$0
        mem[28] = 32'h00225026; // xor  $10,$1,$2
        mem[29] = 32'h00225824; // and  $11,$1,$2
        mem[30] = 32'h00226025; // or   $12,$1,$2
        mem[31] = 32'hFC000000; // halt

        mem_delay = 0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req",     32'(imem_req), 32'd0);
        check("rst_addr",    imem_addr,     32'd0);
        check("rst_dout",    Dout,          32'd0);
        check("rst_flags",   32'(flags),    32'd0);
        check("rst_retired", 32'(retired),  32'd0);
        check("rst_halted",  32'(halted),   32'd0);
        @(negedge clk);
        reset = 1'b1;

        total = 0;
        wait_retire("addi1", 4, c); total += c;
        wait_retire("addi2", 4, c); total += c;
        wait_retire("add3",  4, c); total += c;
        check("add3_total",   32'(total),   32'd12);
        check("add3_dout",    Dout,         32'd2);
        check("add3_retired", 32'(retired), 32'd3);
        check("add3_flags",   32'(flags),   32'b0010);

        wait_retire("sub4", 4, c);
        check("sub4_dout",  Dout,       32'd0);
        check("sub4_flags", 32'(flags), 32'b0110);

        wait_retire("addi5", 4, c);
        check("addi5_dout", Dout, 32'hFFFF8000);
        for (int i = 0; i < 16; i++) wait_retire("dbl5", 4, c);
        check("dbl5_dout",  Dout,       32'h80000000);
        check("dbl5_flags", 32'(flags), 32'b1010);

        wait_retire("nor5", 4, c);
        check("nor5_dout",  Dout,       32'h7FFFFFFF);
        check("nor5_flags", 32'(flags), 32'b0000);

        wait_retire("ovf6", 4, c);
        check("ovf6_dout",  Dout,       32'hFFFFFFFE);
        check("ovf6_flags", 32'(flags), 32'b1001);

        check("r0_pc_before", imem_addr, 32'd92);
        wait_retire("r0w", 4, c);
        check("r0w_dout",    Dout,         32'hFFFFFFFE);
        check("r0w_retired", 32'(retired), 32'd24);
        check("r0w_pc",      imem_addr,    32'd96);
        check("r0w_flags",   32'(flags),   32'b0000);

        wait_retire("r0rd", 4, c);
        check("r0rd_dout", Dout, 32'd5);

        wait_retire("slt8", 4, c);
        check("slt8_dout",  Dout,       32'd1);
        check("slt8_flags", 32'(flags), 32'b0000);

        wait_retire("badfn", 4, c);
        check("badfn_dout",    Dout,         32'd1);
        check("badfn_retired", 32'(retired), 32'd27);
        check("badfn_pc",      imem_addr,    32'd108);

        wait_retire("r9rd", 4, c);
        check("r9rd_dout",  Dout,       32'd0);
        check("r9rd_flags", 32'(flags), 32'b0100);

        wait_retire("xor10", 4, c);
        check("xor10_dout",  Dout,       32'hFFFFFFF8);
        check("xor10_flags", 32'(flags), 32'b1000);
        wait_retire("and11", 4, c);
        check("and11_dout", Dout, 32'd5);
        wait_retire("or12", 4, c);
        check("or12_dout",    Dout,         32'hFFFFFFFD);
        check("or12_flags",   32'(flags),   32'b1000);
        check("or12_retired", 32'(retired), 32'd31);

        // Halt word: halted rises at the edge that ends DECODE.
        @(posedge clk); #1;
        check("halt_early", 32'(halted), 32'd0);
        @(posedge clk); #1;
        check("halt_set", 32'(halted), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("halt_req",     32'(imem_req), 32'd0);
            check("halt_retired", 32'(retired),  32'd31);
            check("halt_flags",   32'(flags),    32'b1000);
            check("halt_pc",      imem_addr,     32'd124);
        end

        // Reset out of HALT, then fetch with a 3-cycle memory delay.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("hrst_req",    32'(imem_req), 32'd0);
        check("hrst_halted", 32'(halted),   32'd0);
        check("hrst_retired",32'(retired),  32'd0);
        check("hrst_flags",  32'(flags),    32'd0);
        check("hrst_dout",   Dout,          32'd0);
        mem_delay = 3;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("slow_req",     32'(imem_req), 32'd1);
            check("slow_addr",    imem_addr,     32'd0);
            check("slow_retired", 32'(retired),  32'd0);
        end
        wait_retire("slow_tail", 4, c);
        check("slow_dout",    Dout,         32'd5);
        check("slow_retired", 32'(retired), 32'd1);

        // Second slow instruction: 4 FETCH + DECODE edges puts it in EXEC.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid_pc_pre", imem_addr, 32'd4);
        reset = 1'b0;
        #1;
        check("mid_pc",      imem_addr,     32'd0);
        check("mid_retired", 32'(retired),  32'd0);
        check("mid_dout",    Dout,          32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_fetch_req",  32'(imem_req), 32'd1);
        check("mid_fetch_addr", imem_addr,     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle successor to the single-cycle R-type datapath. Fetches 32-bit MIPS-format instructions over a request/valid handshake, then decodes, executes and writes back under a five-state FSM. Adds `addi`, a `halt` opcode, registered ALU flags and a retired-instruction counter. Sits between the instruction memory and the test harness; one instruction completes in 4 cycles when memory answers immediately.

## Interface
- `XLEN`, default 32: data and register width; must be ≥16.
- `NREGS`, default 32: register count, one of 8, 16 or 32; indexed by the low log2(NREGS) bits of each 5-bit field.
- `PC_W`, default 32: program counter width.
- `CNT_W`, default 16: retired-counter width.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low; clears all state.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, PC_W: byte address of the fetch (current PC).
- `imem_valid`, in, 1: `imem_data` is valid this cycle.
- `imem_data`, in, 32: instruction word.
- `Dout`, out, XLEN: last written-back result.
- `flags`, out, 4: {N,Z,C,V} from the last executed ALU operation.
- `retired`, out, CNT_W: count of completed instructions.
- `halted`, out, 1: core has stopped.

## Operation
- Reset values: PC=0, state FETCH, all registers 0, `Dout`=0, `flags`=0, `retired`=0, `halted`=0, IR=0, `imem_req`=0 while reset is asserted.
- FETCH: `imem_req`=1 and `imem_addr`=PC, held stable until `imem_valid`. On `imem_valid` IR←`imem_data` and the FSM goes to DECODE. `imem_valid` without `imem_req` is ignored.
- DECODE: A←R[rs]. For R-type B←R[rt]; for `addi` B←sign-extended imm[15:0]. Opcode 0x3F goes to HALT; otherwise go to EXEC.
- EXEC: ALUOut←op(A,B) and flags update, then go to WB.
  - Funct codes: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt (signed; result 1 or 0).
  - Opcode 0x08 performs add.
  - C and V are meaningful only for add and sub; they are 0 for logic ops.
  - N = MSB of the result; Z = result==0.
- WB:
  - Destination is rd for R-type and rt for `addi`.
  - The write is suppressed when the destination is register 0, the opcode is unknown, or the funct is unknown.
  - `Dout`←ALUOut only when the write happens.
  - PC←PC+4, wrapping modulo 2^PC_W.
  - `retired`+1, wrapping.
  - Return to FETCH.
- Unknown opcode or funct: executes as a NOP. The flags still update from the computed ALU result, the instruction still retires and PC still advances.
- HALT: `halted`=1, `imem_req`=0, PC frozen; only `reset` leaves this state.
- Register 0 always reads 0.
- All arithmetic wraps at XLEN.
- `reset` asserted in any state returns immediately to reset values; a fetch in progress is abandoned.

## Timing
- Minimum 4 cycles per instruction (FETCH, DECODE, EXEC, WB). Each cycle FETCH waits for `imem_valid` adds one cycle.
- A register written in WB is visible to the next instruction's DECODE, so no forwarding is needed.
- `Dout`, `retired` and PC update on the clock edge that ends WB.
- `flags` update on the clock edge that ends EXEC.
- `halted` rises on the clock edge that ends DECODE of the halt word.
- Outputs are registered, except `imem_req` and `imem_addr`, which are decoded from state and PC.

## Structure
- Package `datapath_pkg` holds:
  - state enum {FETCH, DECODE, EXEC, WB, HALT};
  - opcode constants OP_RTYPE=0x00, OP_ADDI=0x08, OP_HALT=0x3F;
  - funct constants;
  - 4-bit ALU-op enum.
- Sub-module `alu_param` (parameter XLEN): combinational; inputs A, B and ALU op; outputs result and N/Z/C/V.
- The register file is inline, NREGS×XLEN, with 2 read ports and 1 write port.

## Test plan
- Reset with memory answering same-cycle, running `addi $1,$0,5` then `addi $2,$0,-3` then `add $3,$1,$2`:
  - `Dout`=2 after cycle 12;
  - `retired`=3;
  - `flags` N=0, Z=0, C=1.
- `sub $4,$1,$1`: `Dout`=0; flags Z=1, N=0, C=1, V=0.
- With $5=0x7FFFFFFF, `add $6,$5,$5`: `Dout`=0xFFFFFFFE; flags V=1, N=1.
- `add $0,$1,$1`: R0 still reads 0; `Dout` unchanged; `retired` increments; PC advances by 4.
- `imem_valid` delayed 3 cycles:
  - `imem_req` and `imem_addr` stay stable throughout;
  - instruction completes in 7 cycles.
  - `reset` pulsed low mid-EXEC: PC=0, `retired`=0, state FETCH on the next cycle.
- Halt word 0xFC000000:
  - `halted`=1;
  - `imem_req`=0 forever;
  - `retired` frozen;
  - `flags` unchanged.
  - After reset, fetch resumes at address 0.
